// File: rtl/sc_dma_pkg.sv
// rtl/sc_dma_pkg.sv - shared state type and constants for the sc_dmem_dma block-copy engine
package sc_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_VRD,
    ST_VCHK,
    ST_FIN
  } dma_state_e;

  // byte distance between consecutive memory words
  localparam int WORD_STEP = 4;

  // reset contents of the address and data registers
  localparam logic [31:0] ADDR_RST = 32'h0000_0000;
  localparam logic [31:0] DATA_RST = 32'h0000_0000;

endpackage

// File: rtl/sc_dmem_dma_if.sv
// rtl/sc_dmem_dma_if.sv - data-memory port bundle shared by the copy engine and the memory side
interface sc_dmem_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              mwe;
  logic [DATA_W-1:0] mrdata;

  modport master (output maddr, output mwdata, output mwe, input mrdata);
  modport slave  (input maddr, input mwdata, input mwe, output mrdata);

endinterface

// File: rtl/sc_dma_addr_ctr.sv
// rtl/sc_dma_addr_ctr.sv - source/destination pointer pair and remaining-word down-counter
module sc_dma_addr_ctr
  import sc_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic              last
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  // load on an accepted start, advance one word per finished copy; addresses wrap naturally
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      rem_d = cnt_in;
    end else if (step) begin
      src_d = src_q + ADDR_W'(WORD_STEP);
      dst_d = dst_q + ADDR_W'(WORD_STEP);
      rem_d = rem_q - CNT_W'(1);
    end
  end

  // pointer and counter registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      src_q <= ADDR_W'(ADDR_RST);
      dst_q <= ADDR_W'(ADDR_RST);
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src  = src_q;
  assign dst  = dst_q;
  // the word in flight is the final one, so the coming step empties the counter
  assign last = (rem_q == CNT_W'(1));

endmodule

// File: rtl/sc_dmem_dma.sv
// rtl/sc_dmem_dma.sv - word block-copy engine on the data-memory port; SC_DMA_VERIFY_EN adds read-back verify
module sc_dmem_dma
  import sc_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  sc_dmem_dma_if.master        mem
);

  dma_state_e        state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              last;
  logic              accept;
  logic              step;

  assign accept = (state_q == ST_IDLE) && start;

`ifdef SC_DMA_VERIFY_EN
  assign step = (state_q == ST_VCHK);
`else
  assign step = (state_q == ST_WR);
`endif

  sc_dma_addr_ctr #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_ctr (
    .clock  (clock),
    .resetn (resetn),
    .load   (accept),
    .step   (step),
    .src_in (src_addr & ~ADDR_W'(3)),
    .dst_in (dst_addr & ~ADDR_W'(3)),
    .cnt_in (count),
    .src    (src_ptr),
    .dst    (dst_ptr),
    .last   (last)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state: read, capture, write (optionally read back and check) per word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (count == '0) ? ST_FIN : ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_WR;
`ifdef SC_DMA_VERIFY_EN
      ST_WR:   state_d = ST_VRD;
      ST_VRD:  state_d = ST_VCHK;
      ST_VCHK: state_d = last ? ST_FIN : ST_RD;
`else
      ST_WR:   state_d = last ? ST_FIN : ST_RD;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs: status flags and memory-port drive; the address holds between accesses
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mem.mwe = 1'b0;
    maddr_d = maddr_q;
    case (state_q)
      ST_RD:   begin busy = 1'b1; maddr_d = src_ptr; end
      ST_CAP:  busy = 1'b1;
      ST_WR:   begin busy = 1'b1; mem.mwe = 1'b1; maddr_d = dst_ptr; end
      ST_VRD:  begin busy = 1'b1; maddr_d = dst_ptr; end
      ST_VCHK: busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign mem.maddr  = maddr_d;
  assign mem.mwdata = buf_q;

  // word buffer captures read data the cycle after the source address was shown
  always_comb begin
    buf_d = buf_q;
    if (state_q == ST_CAP) buf_d = mem.mrdata;
  end

  // datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      buf_q   <= DATA_W'(DATA_RST);
      maddr_q <= ADDR_W'(ADDR_RST);
    end else begin
      buf_q   <= buf_d;
      maddr_q <= maddr_d;
    end
  end

`ifdef SC_DMA_VERIFY_EN
  logic error_q, error_d;

  // sticky mismatch flag; a new transfer clears it, a mismatch does not stop the copy
  always_comb begin
    error_d = error_q;
    if (accept)                                          error_d = 1'b0;
    else if (state_q == ST_VCHK && mem.mrdata != buf_q)  error_d = 1'b1;
  end

  // error flag register
  always_ff @(posedge clock) begin
    if (!resetn) error_q <= 1'b0;
    else         error_q <= error_d;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
